// File: rtl/gtrg_rdr_pkg.sv
`default_nettype none
// ============================================================================
// gtrg_rdr_pkg : shared types and constants for the GTRG event reader. Rev 1.0
// ============================================================================
package gtrg_rdr_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WAIT  = 3'd1,
    ST_LATCH = 3'd2,
    ST_HDR   = 3'd3,
    ST_RDOUT = 3'd4,
    ST_TRL   = 3'd5
  } state_e;

  localparam logic [3:0] MRK_W0  = 4'h9;
  localparam logic [3:0] MRK_W1  = 4'hA;
  localparam logic [3:0] MRK_W2  = 4'hB;
  localparam logic [3:0] MRK_W3  = 4'hC;
  localparam logic [3:0] MRK_W4  = 4'hD;
  localparam logic [3:0] MRK_TRL = 4'hE;

  // DAVSOUT = {alct, lct_or[5:1], cfeb_mov[5:1], cfeb_dav[5:1], tmb}
  localparam int DAV_TMB      = 0;
  localparam int DAV_CFEB_LSB = 1;
  localparam int DAV_MOV_LSB  = 6;
  localparam int DAV_LCT_LSB  = 11;
  localparam int DAV_ALCT     = 16;

  // RDREQ/RDDONE = {alct, tmb, cfeb[5:1]}
  localparam int SRC_CFEB_LSB = 0;
  localparam int SRC_TMB      = 5;
  localparam int SRC_ALCT     = 6;
  localparam int N_SRC        = 7;

  localparam int TMO_W_DEF    = 12;

  function automatic logic [N_SRC-1:0] src_mask(input logic [16:0] dav);
    logic [N_SRC-1:0] m;
    m = '0;
    m[SRC_ALCT]                = dav[DAV_ALCT];
    m[SRC_TMB]                 = dav[DAV_TMB];
    m[SRC_CFEB_LSB +: 5]       = dav[DAV_CFEB_LSB +: 5];
    return m;
  endfunction

endpackage
`default_nettype wire

// File: rtl/gtrg_rdr_tmo.sv
`default_nettype none
// ============================================================================
// gtrg_rdr_tmo : clearable up counter with all-ones terminal count. Rev 1.0
// ============================================================================
module gtrg_rdr_tmo #(
  parameter int TMO_W = 12
) (
  input  logic clk_i,
  input  logic rst_b_i,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  logic [TMO_W-1:0] cnt_q;
  logic [TMO_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_b_i) begin
    if (!rst_b_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = &cnt_q;

endmodule
`default_nettype wire

// File: rtl/gtrg_evt_reader.sv
`default_nettype none
// ============================================================================
// gtrg_evt_reader : GTRG FIFO read side -> header, source readout, trailer.
// Optional DOUT parity output enabled by GTRG_EVT_READER_PARITY_EN.  Rev 1.0
// ============================================================================
module gtrg_evt_reader
  import gtrg_rdr_pkg::*;
#(
  parameter int TMO_W    = TMO_W_DEF,
  parameter int HDR_WAIT = 2
) (
  input  logic        clk_i,
  input  logic        rst_b_i,
  input  logic        l1arst_i,
  input  logic        empty_b_i,
  input  logic [16:0] davsout_i,
  input  logic [11:0] bxcount_i,
  input  logic [3:0]  cfebbx_i,
  output logic        pop_o,
  output logic [6:0]  rdreq_o,
  input  logic [6:0]  rddone_i,
  output logic [15:0] dout_o,
  output logic        dvalid_o,
  input  logic        ready_i,
  output logic        busy_o,
`ifdef GTRG_EVT_READER_PARITY_EN
  output logic        dpar_o,
`endif
  output logic        tmoerr_o
);

  localparam int WC = (HDR_WAIT > 1) ? $clog2(HDR_WAIT) : 1;

  state_e      state_q, state_d;
  logic [WC-1:0] wcnt_q, wcnt_d;
  logic [2:0]  idx_q, idx_d;
  logic [16:0] dav_q, dav_d;
  logic [11:0] bx_q, bx_d;
  logic [3:0]  cbx_q, cbx_d;
  logic [11:0] evt_hi_q, evt_hi_d;
  logic [6:0]  pend_q, pend_d;
  logic [6:0]  tomask_q, tomask_d;
  logic [15:0] dout_q, dout_d;
  logic        dvalid_q, dvalid_d;
  logic [23:0] evt_cnt_q, evt_cnt_d;

  logic        tmo_tc;
  logic        tmo_pulse;
  logic        accept;
  logic [2:0]  idx_nx;
  logic [15:0] hdr_nx;
  logic [6:0]  remain;

  gtrg_rdr_tmo #(
    .TMO_W (TMO_W)
  ) u_tmo (
    .clk_i   (clk_i),
    .rst_b_i (rst_b_i),
    .clr_i   (state_q != ST_RDOUT),
    .en_i    (1'b1),
    .tc_o    (tmo_tc)
  );

  assign accept = dvalid_q & ready_i;
  assign idx_nx = idx_q + 3'd1;
  assign remain = pend_q & ~rddone_i;

  // Header words 1..4 come from fields captured in LATCH, never from live inputs.
  always_comb begin
    hdr_nx = '0;
    case (idx_nx)
      3'd1:    hdr_nx = {MRK_W1, evt_hi_q};
      3'd2:    hdr_nx = {MRK_W2, bx_q};
      3'd3:    hdr_nx = {MRK_W3, cbx_q, dav_q[DAV_ALCT], dav_q[DAV_TMB],
                         dav_q[DAV_CFEB_LSB +: 5], 1'b0};
      default: hdr_nx = {MRK_W4, 1'b0, dav_q[DAV_LCT_LSB +: 5],
                         dav_q[DAV_MOV_LSB +: 5], 1'b0};
    endcase
  end

  always_comb begin
    state_d   = state_q;
    wcnt_d    = wcnt_q;
    idx_d     = idx_q;
    dav_d     = dav_q;
    bx_d      = bx_q;
    cbx_d     = cbx_q;
    evt_hi_d  = evt_hi_q;
    pend_d    = pend_q;
    tomask_d  = tomask_q;
    dout_d    = dout_q;
    dvalid_d  = dvalid_q;
    evt_cnt_d = evt_cnt_q;
    tmo_pulse = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (empty_b_i) begin
          state_d = ST_WAIT;
          wcnt_d  = WC'(HDR_WAIT - 1);
        end
      end
      ST_WAIT: begin
        if (wcnt_q == '0) begin
          state_d = ST_LATCH;
        end else begin
          wcnt_d = wcnt_q - 1'b1;
        end
      end
      ST_LATCH: begin
        dav_d    = davsout_i;
        bx_d     = bxcount_i;
        cbx_d    = cfebbx_i;
        evt_hi_d = evt_cnt_q[23:12];
        tomask_d = '0;
        idx_d    = '0;
        dout_d   = {MRK_W0, evt_cnt_q[11:0]};
        dvalid_d = 1'b1;
        state_d  = ST_HDR;
      end
      ST_HDR: begin
        if (accept) begin
          if (idx_q == 3'd4) begin
            dvalid_d = 1'b0;
            pend_d   = src_mask(dav_q);
            state_d  = ST_RDOUT;
          end else begin
            idx_d  = idx_nx;
            dout_d = hdr_nx;
          end
        end
      end
      ST_RDOUT: begin
        // A done pulse in the terminal-count cycle still clears its bit.
        pend_d = remain;
        if (remain == '0) begin
          dout_d   = {MRK_TRL, 5'b0, tomask_q};
          dvalid_d = 1'b1;
          state_d  = ST_TRL;
        end else if (tmo_tc) begin
          tmo_pulse = 1'b1;
          tomask_d  = remain;
          pend_d    = '0;
          dout_d    = {MRK_TRL, 5'b0, remain};
          dvalid_d  = 1'b1;
          state_d   = ST_TRL;
        end
      end
      ST_TRL: begin
        if (accept) begin
          dvalid_d  = 1'b0;
          evt_cnt_d = evt_cnt_q + 24'd1;
          state_d   = ST_IDLE;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        dvalid_d = 1'b0;
      end
    endcase

    if (l1arst_i) begin
      evt_cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_b_i) begin
    if (!rst_b_i) begin
      state_q   <= ST_IDLE;
      wcnt_q    <= '0;
      idx_q     <= '0;
      dav_q     <= '0;
      bx_q      <= '0;
      cbx_q     <= '0;
      evt_hi_q  <= '0;
      pend_q    <= '0;
      tomask_q  <= '0;
      dout_q    <= '0;
      dvalid_q  <= 1'b0;
      evt_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      wcnt_q    <= wcnt_d;
      idx_q     <= idx_d;
      dav_q     <= dav_d;
      bx_q      <= bx_d;
      cbx_q     <= cbx_d;
      evt_hi_q  <= evt_hi_d;
      pend_q    <= pend_d;
      tomask_q  <= tomask_d;
      dout_q    <= dout_d;
      dvalid_q  <= dvalid_d;
      evt_cnt_q <= evt_cnt_d;
    end
  end

`ifdef GTRG_EVT_READER_PARITY_EN
  logic dpar_q;

  always_ff @(posedge clk_i or negedge rst_b_i) begin
    if (!rst_b_i) begin
      dpar_q <= 1'b0;
    end else begin
      dpar_q <= ^dout_d;
    end
  end

  assign dpar_o = dpar_q;
`endif

  assign pop_o    = (state_q == ST_LATCH);
  assign rdreq_o  = (state_q == ST_RDOUT) ? pend_q : 7'd0;
  assign dout_o   = dout_q;
  assign dvalid_o = dvalid_q;
  assign busy_o   = (state_q != ST_IDLE);
  assign tmoerr_o = tmo_pulse;

endmodule
`default_nettype wire
